// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: UART timing constants shared with the transmitter, plus receiver helpers.
`ifndef UART_VH
`define UART_VH
`define UartDivCnt 15
`define UartDivCntW 4
`define UartBitCnt 8
`define UartBitCntW 3
`define UartHalfCnt (`UartDivCnt/2)
`endif

package uart_rx_pkg;
    localparam logic [`UartBitCntW-1:0] BitLast = `UartBitCntW'(`UartBitCnt - 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// sync_2ff: generic two-flop synchronizer with a configurable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[0], d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {2{RST_VAL}};
        else     sync_q <= sync_d;
    end

    assign q = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with valid/ready byte output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling (needs DIV_CNT >= 4).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DIV_CNT = `UartDivCnt,
    parameter int DIV_W   = `UartDivCntW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    localparam logic [DIV_W-1:0] DivLast = DIV_W'(DIV_CNT);
    localparam logic [DIV_W-1:0] DivHalf = DIV_W'(DIV_CNT / 2);

    state_e                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [`UartBitCntW-1:0] bit_q, bit_d;
    logic [7:0]             shift_q, shift_d, data_q, data_d;
    logic                   valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                   prev_q, prev_d, rxs, samp;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rxs));

`ifdef UART_RX_MAJORITY_EN
    logic prev2_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev2_q <= 1'b1;
        else     prev2_q <= prev_q;
    end
    assign samp = maj3(rxs, prev_q, prev2_q);
`else
    assign samp = rxs;
`endif

    always_comb begin
        state_d = state_q;
        div_d   = div_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~rx_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        prev_d  = rxs;
        case (state_q)
            IDLE: begin
                div_d = '0;
                // Edge-triggered so a held-low break cannot restart a frame
                if (prev_q && !rxs) state_d = START;
            end
            START: if (div_q == DivHalf) begin
                div_d   = '0;
                bit_d   = '0;
                state_d = samp ? IDLE : DATA;
            end
            DATA: if (div_q == DivLast) begin
                div_d   = '0;
                shift_d = {samp, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == BitLast) state_d = STOP;
            end
            STOP: if (div_q == DivLast) begin
                div_d   = '0;
                state_d = IDLE;
                if (!samp) ferr_d = 1'b1;
                else if (!valid_q || rx_ready) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end else ovr_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            prev_q  <= prev_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign rx_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames at 16 clk/bit and scores received bytes against an expected-byte queue.
module tb_uart_rx;
    localparam int BIT = 16;

    logic       clk = 1'b0, rst = 1'b1, rx = 1'b1;
    logic       man_rdy = 1'b0, stall_rdy = 1'b1, stall_en = 1'b0;
    logic       rx_ready, rx_valid, frame_err, overrun, rx_busy;
    logic [7:0] rx_data;

    int n_vec = 0, n_bad = 0, n_acc = 0, n_ferr = 0, n_ovr = 0;
    byte unsigned exp_q[$];

    assign rx_ready = stall_en ? stall_rdy : man_rdy;

    uart_rx #(.DIV_CNT(15), .DIV_W(4)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted byte must be the oldest expected one
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (rx_valid && rx_ready) begin
                n_acc++;
                if (exp_q.size() == 0) check("spurious_byte", exp_q.size(), 1);
                else check("byte", rx_data, exp_q.pop_front());
            end
        end
    end

    // Consumer stalls stay well under one frame so no overrun is legal
    initial forever begin
        @(posedge clk);
        if (stall_en) begin
            #1 stall_rdy = 1'b0;
            repeat ($urandom_range(0, 100)) @(posedge clk);
            #1 stall_rdy = 1'b1;
            repeat ($urandom_range(1, 20)) @(posedge clk);
        end
    end

    task automatic send(input logic [7:0] b, input logic stop, input int nbits);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            repeat (BIT) @(posedge clk);
        end
    endtask

    initial begin
        int a, f, o;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", rx_busy, 0);
        @(posedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Two bytes back to back, always ready
        a = n_acc; f = n_ferr; o = n_ovr;
        man_rdy = 1'b1;
        exp_q.push_back(8'h55); send(8'h55, 1'b1, 10);
        exp_q.push_back(8'hA3); send(8'hA3, 1'b1, 10);
        repeat (BIT) @(posedge clk);
        @(negedge clk);
        check("t1_count", n_acc - a, 2);
        check("t1_drain", exp_q.size(), 0);
        check("t1_ferr", n_ferr - f, 0);
        check("t1_ovr", n_ovr - o, 0);

        // Short glitch: false start
        a = n_acc;
        rx = 1'b0; repeat (4) @(posedge clk);
        rx = 1'b1; repeat (2) @(posedge clk);
        @(negedge clk);
        check("t2_busy", rx_busy, 1);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("t2_idle", rx_busy, 0);
        check("t2_count", n_acc - a, 0);

        // Framing error followed by a long break, then a good byte
        a = n_acc; f = n_ferr;
        send(8'h3C, 1'b0, 10);
        rx = 1'b0;
        repeat (40 * BIT) @(posedge clk);
        @(negedge clk);
        check("t3_ferr", n_ferr - f, 1);
        check("t3_count", n_acc - a, 0);
        check("t3_busy", rx_busy, 0);
        rx = 1'b1;
        repeat (BIT) @(posedge clk);
        exp_q.push_back(8'h5A); send(8'h5A, 1'b1, 10);
        repeat (BIT) @(posedge clk);
        @(negedge clk);
        check("t3_after", n_acc - a, 1);

        // Overrun: second byte dropped while first is unaccepted
        o = n_ovr;
        man_rdy = 1'b0;
        exp_q.push_back(8'h11);
        send(8'h11, 1'b1, 10);
        send(8'h22, 1'b1, 10);
        repeat (BIT) @(posedge clk);
        @(negedge clk);
        check("t4_valid", rx_valid, 1);
        check("t4_data", rx_data, 8'h11);
        check("t4_ovr", n_ovr - o, 1);
        @(posedge clk); #1 man_rdy = 1'b1;
        @(posedge clk); #1 man_rdy = 1'b0;
        @(negedge clk);
        check("t4_clear", rx_valid, 0);
        check("t4_drain", exp_q.size(), 0);

        // Reset in the middle of a frame
        a = n_acc; f = n_ferr; o = n_ovr;
        send(8'hF0, 1'b1, 5);
        rx = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("t5_busy", rx_busy, 0);
        repeat (3) @(posedge clk);
        rst = 1'b0;
        man_rdy = 1'b1;
        repeat (BIT) @(posedge clk);
        exp_q.push_back(8'h0F); send(8'h0F, 1'b1, 10);
        repeat (BIT) @(posedge clk);
        @(negedge clk);
        check("t5_count", n_acc - a, 1);
        check("t5_ferr", n_ferr - f, 0);
        check("t5_ovr", n_ovr - o, 0);

        // 256-byte stream with random consumer stalls
        a = n_acc; f = n_ferr; o = n_ovr;
        stall_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(8'(i));
            send(8'(i), 1'b1, 10);
            repeat ($urandom_range(0, 8)) @(posedge clk);
        end
        repeat (200) @(posedge clk);
        stall_en = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t6_count", n_acc - a, 256);
        check("t6_drain", exp_q.size(), 0);
        check("t6_ferr", n_ferr - f, 0);
        check("t6_ovr", n_ovr - o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
